// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
//   Bundles the requester-side handshake and the shared-register outputs of
//   shared_reg_arbiter.
//   Signals:
//     REQ        per-requester request level (requesters -> arbiter)
//     WR_DATA    packed write data, requester i on [i*WIDTH +: WIDTH]
//     GNT        one-hot grant
//     OWNER      index of current or last grantee
//     BUSY       arbiter in GRANT or HOLD
//     DONE       data committed, grant held
//     ERR        one-cycle pulse on timeout release
//     REG_Q      shared register contents
//     REG_Q_bar  bitwise complement of REG_Q
//   Modports: master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*WIDTH-1:0] WR_DATA;
    logic [N_REQ-1:0]       GNT;
    logic [IDX_W-1:0]       OWNER;
    logic                   BUSY;
    logic                   DONE;
    logic                   ERR;
    logic [WIDTH-1:0]       REG_Q;
    logic [WIDTH-1:0]       REG_Q_bar;

    modport master (
        output REQ, WR_DATA,
        input  GNT, OWNER, BUSY, DONE, ERR, REG_Q, REG_Q_bar
    );

    modport slave (
        input  REQ, WR_DATA,
        output GNT, OWNER, BUSY, DONE, ERR, REG_Q, REG_Q_bar
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter owning a single WIDTH-bit shared register. One
//   requester at a time is granted; its data is committed on the GRANT->HOLD
//   edge and the grant is held until the requester drops REQ or a timeout
//   watchdog forces release.
//   Ports:
//     CLK   clock, rising edge
//     RST   asynchronous active-high reset
//     bus   shared_reg_arbiter_if.slave (REQ/WR_DATA in; GNT, OWNER, BUSY,
//           DONE, ERR, REG_Q, REG_Q_bar out)
module shared_reg_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    shared_reg_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   reg_q, reg_d;

    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   scan_idx;
    logic               found;
    logic [IDX_W-1:0]   ptr_next;

    // Round-robin search starting at ptr_q; the explicit modulo keeps the
    // wrap correct when N_REQ is not a power of two.
    always_comb begin
        win      = ptr_q;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && bus.REQ[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    assign ptr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        reg_d   = reg_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    owner_d = win;
                    gnt_d   = N_REQ'(1) << win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Commit unconditionally: a requester that already dropped
                // REQ still gets its data written.
                reg_d   = bus.WR_DATA[int'(owner_q)*WIDTH +: WIDTH];
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!bus.REQ[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            reg_q   <= reg_d;
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.OWNER     = owner_q;
    assign bus.BUSY      = (state_q == GRANT) || (state_q == HOLD);
    assign bus.DONE      = (state_q == HOLD);
    assign bus.ERR       = err_q;
    assign bus.REG_Q     = reg_q;
    assign bus.REG_Q_bar = ~reg_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, TIMEOUT=15).
module tb_shared_reg_arbiter;
    logic CLK;
    logic RST;
    int   total;
    int   bad;

    shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .TIMEOUT(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        bus.WR_DATA[idx*8 +: 8] = val;
    endtask

    int          cyc;
    int          done_len;
    logic [7:0]  rr_data [4];
    int          rr_order [5];

    initial begin
        total = 0;
        bad   = 0;
        rr_data  = '{8'h10, 8'h21, 8'h32, 8'h43};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset with random inputs
        RST         = 1'b1;
        bus.REQ     = 4'($urandom);
        bus.WR_DATA = 32'($urandom);
        tick();
        tick();
        chk("rst_gnt",   32'(bus.GNT), 32'h0);
        chk("rst_done",  32'(bus.DONE), 32'h0);
        chk("rst_err",   32'(bus.ERR), 32'h0);
        chk("rst_busy",  32'(bus.BUSY), 32'h0);
        chk("rst_q",     32'(bus.REG_Q), 32'h00);
        chk("rst_qbar",  32'(bus.REG_Q_bar), 32'hFF);
        bus.REQ = 4'b0000;
        RST     = 1'b0;
        tick();

        // Single request from requester 1
        bus.WR_DATA = 32'h44_33_A5_11;
        bus.REQ     = 4'b0010;
        tick();
        chk("single_gnt",   32'(bus.GNT), 32'h2);
        chk("single_owner", 32'(bus.OWNER), 32'h1);
        chk("single_busy",  32'(bus.BUSY), 32'h1);
        chk("single_done0", 32'(bus.DONE), 32'h0);
        chk("single_q0",    32'(bus.REG_Q), 32'h00);
        tick();
        chk("single_q",     32'(bus.REG_Q), 32'hA5);
        chk("single_qbar",  32'(bus.REG_Q_bar), 32'h5A);
        chk("single_done",  32'(bus.DONE), 32'h1);
        bus.REQ = 4'b0000;
        tick();
        chk("single_rel_gnt",  32'(bus.GNT), 32'h0);
        chk("single_rel_done", 32'(bus.DONE), 32'h0);
        chk("single_rel_busy", 32'(bus.BUSY), 32'h0);
        // PTR=2: among {0,1,3} the search must land on 3
        bus.REQ = 4'b1011;
        tick();
        chk("ptr2_gnt",   32'(bus.GNT), 32'h8);
        chk("ptr2_owner", 32'(bus.OWNER), 32'h3);
        tick();
        chk("ptr2_q", 32'(bus.REG_Q), 32'h44);
        bus.REQ = 4'b0000;
        tick();
        chk("ptr2_rel", 32'(bus.GNT), 32'h0);

        // Round-robin contention, PTR=0
        for (int i = 0; i < 4; i++) set_data(i, rr_data[i]);
        bus.REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = rr_order[k];
            tick();
            chk("rr_gnt",    32'(bus.GNT), 32'(1 << w));
            chk("rr_onehot", 32'($onehot0(bus.GNT)), 32'h1);
            tick();
            chk("rr_done", 32'(bus.DONE), 32'h1);
            chk("rr_q",    32'(bus.REG_Q), 32'(rr_data[w]));
            tick();
            tick();
            chk("rr_hold_gnt", 32'(bus.GNT), 32'(1 << w));
            bus.REQ[w] = 1'b0;
            tick();
            chk("rr_rel_gnt",  32'(bus.GNT), 32'h0);
            chk("rr_rel_busy", 32'(bus.BUSY), 32'h0);
            if (k < 4) bus.REQ[w] = 1'b1;
            else       bus.REQ = 4'b0000;
        end

        // Early drop: PTR=1, requester 3 pulses one cycle
        set_data(3, 8'h3C);
        bus.REQ = 4'b1000;
        tick();
        chk("early_gnt", 32'(bus.GNT), 32'h8);
        bus.REQ = 4'b0000;
        tick();
        chk("early_q",    32'(bus.REG_Q), 32'h3C);
        chk("early_done", 32'(bus.DONE), 32'h1);
        tick();
        chk("early_done_off", 32'(bus.DONE), 32'h0);
        chk("early_gnt_off",  32'(bus.GNT), 32'h0);

        // Timeout: PTR=0, requester 2 holds REQ forever
        set_data(0, 8'h0A);
        set_data(2, 8'h77);
        bus.REQ = 4'b0100;
        tick();
        chk("to_gnt", 32'(bus.GNT), 32'h4);
        bus.REQ = 4'b0101;
        tick();
        chk("to_q", 32'(bus.REG_Q), 32'h77);
        done_len = 0;
        cyc      = 0;
        while (bus.DONE === 1'b1 && cyc < 40) begin
            chk("to_err_low", 32'(bus.ERR), 32'h0);
            done_len++;
            cyc++;
            tick();
        end
        chk("to_len",  32'(done_len), 32'd15);
        chk("to_err",  32'(bus.ERR), 32'h1);
        chk("to_gnt0", 32'(bus.GNT), 32'h0);
        chk("to_busy", 32'(bus.BUSY), 32'h0);
        tick();
        chk("to_err_pulse", 32'(bus.ERR), 32'h0);
        chk("to_next_gnt",  32'(bus.GNT), 32'h1);
        bus.REQ = 4'b0000;
        tick();
        chk("to_next_q", 32'(bus.REG_Q), 32'h0A);
        tick();
        chk("to_next_rel", 32'(bus.GNT), 32'h0);

        // Reset mid-HOLD (PTR=1 going in)
        set_data(2, 8'h5A);
        bus.REQ = 4'b0100;
        tick();
        tick();
        chk("mid_gnt_pre", 32'(bus.GNT), 32'h4);
        chk("mid_q_pre",   32'(bus.REG_Q), 32'h5A);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_gnt",   32'(bus.GNT), 32'h0);
        chk("mid_q",     32'(bus.REG_Q), 32'h00);
        chk("mid_qbar",  32'(bus.REG_Q_bar), 32'hFF);
        chk("mid_done",  32'(bus.DONE), 32'h0);
        chk("mid_busy",  32'(bus.BUSY), 32'h0);
        chk("mid_owner", 32'(bus.OWNER), 32'h0);
        RST = 1'b0;
        tick();
        chk("post_gnt", 32'(bus.GNT), 32'h4);
        tick();
        chk("post_q", 32'(bus.REG_Q), 32'h5A);
        bus.REQ = 4'b0000;
        tick();
        chk("post_rel", 32'(bus.GNT), 32'h0);
        // PTR=3: among {0,1} the search wraps to 0
        bus.REQ = 4'b0011;
        tick();
        chk("wrap_gnt", 32'(bus.GNT), 32'h1);
        bus.REQ = 4'b0000;
        tick();
        tick();
        chk("wrap_rel", 32'(bus.GNT), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
